// File: rtl/macc_frame_gen.sv
// Producer side of a Macc (A, B, tlast) pair stream: per accepted sample, emits
// one NTAPS-beat frame pairing the delay line x[n-k] with coefficient h[k].
module macc_frame_gen #(
  parameter int ADW   = 24,
  parameter int BDW   = 18,
  parameter int NTAPS = 16,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [ADW-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  coef_wr_en,
  input  logic [AW-1:0]         coef_wr_addr,
  input  logic signed [BDW-1:0] coef_wr_data,
  output logic signed [ADW-1:0] m_axis_atdata,
  output logic signed [BDW-1:0] m_axis_btdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         tap_q, tap_d, tap_nxt;
  logic signed [ADW-1:0] a_q, a_d;
  logic signed [BDW-1:0] b_q, b_d;
  logic                  last_q, last_d;
  logic signed [ADW-1:0] dly_q  [NTAPS];
  logic signed [BDW-1:0] coef_q [NTAPS];
  logic                  in_hs, out_hs;

  assign m_axis_tvalid = (state_q == EMIT);
  assign m_axis_tlast  = last_q;
  assign m_axis_atdata = a_q;
  assign m_axis_btdata = b_q;

  // Accept a new sample only when the current frame is finishing (or none is active).
  assign s_axis_tready = !rst && (!m_axis_tvalid || (m_axis_tready && last_q));
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign tap_nxt       = tap_q + AW'(1);

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    if (in_hs) begin
      // Frame start wins over frame end so frames run back-to-back.
      state_d = EMIT;
      tap_d   = '0;
      a_d     = s_axis_tdata;
      b_d     = coef_q[0];
      last_d  = (NTAPS == 1);
    end else if (out_hs) begin
      if (last_q) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end else begin
        // Delay line cannot shift mid-frame, so dly_q is already the post-shift view.
        tap_d  = tap_nxt;
        a_d    = dly_q[tap_nxt];
        b_d    = coef_q[tap_nxt];
        last_d = (tap_nxt == AW'(NTAPS - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
    end
  end

  // Coefficient reads above see the pre-write array, so a same-edge write is not forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (in_hs) begin
        dly_q[0] <= s_axis_tdata;
        for (int i = 1; i < NTAPS; i++) dly_q[i] <= dly_q[i-1];
      end
      if (coef_wr_en && ({1'b0, coef_wr_addr} < (AW+1)'(NTAPS)))
        coef_q[coef_wr_addr] <= coef_wr_data;
    end
  end

endmodule

// File: tb/tb_macc_frame_gen.sv
// Randomized and directed bench for macc_frame_gen with a frame-level reference model.
module tb_macc_frame_gen;
  localparam int ADW = 24, BDW = 18, NT = 4, AW = 2;
  localparam logic signed [ADW-1:0] AMIN = {1'b1, {(ADW-1){1'b0}}};
  localparam logic signed [BDW-1:0] BMIN = {1'b1, {(BDW-1){1'b0}}};

  logic clk = 1'b0, rst = 1'b1;
  logic signed [ADW-1:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tready;
  logic coef_wr_en = 1'b0;
  logic [AW-1:0] coef_wr_addr = '0;
  logic signed [BDW-1:0] coef_wr_data = '0;
  logic signed [ADW-1:0] m_axis_atdata;
  logic signed [BDW-1:0] m_axis_btdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;

  macc_frame_gen #(.ADW(ADW), .BDW(BDW), .NTAPS(NT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .m_axis_atdata(m_axis_atdata), .m_axis_btdata(m_axis_btdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0, cyc = 0, stall_viol = 0, rdy_viol = 0;
  logic signed [ADW-1:0] in_q[$], got_a[$], exp_a[$];
  logic signed [BDW-1:0] got_b[$], exp_b[$];
  logic signed [BDW-1:0] coef_m[NT];
  bit got_l[$], exp_l[$];
  int got_c[$];
  bit stall_p = 0;
  logic signed [ADW-1:0] a_p;
  logic signed [BDW-1:0] b_p;
  logic l_p;

  always @(posedge clk) cyc++;

  // Passive monitor: handshakes are seen at the negedge before the edge that completes them.
  always @(negedge clk) begin
    if (rst) stall_p = 0;
    else begin
      if (stall_p && (m_axis_tvalid !== 1'b1 || m_axis_atdata !== a_p ||
                      m_axis_btdata !== b_p || m_axis_tlast !== l_p)) stall_viol++;
      if (m_axis_tvalid && !(m_axis_tready && m_axis_tlast) && s_axis_tready) rdy_viol++;
      if (s_axis_tvalid && s_axis_tready) in_q.push_back(s_axis_tdata);
      if (m_axis_tvalid && m_axis_tready) begin
        got_a.push_back(m_axis_atdata); got_b.push_back(m_axis_btdata);
        got_l.push_back(m_axis_tlast);  got_c.push_back(cyc);
      end
      stall_p = m_axis_tvalid && !m_axis_tready;
      a_p = m_axis_atdata; b_p = m_axis_btdata; l_p = m_axis_tlast;
    end
  end

  // Frame n, beat k carries (x[n-k] or 0 before the first sample, h[k]), last on k = NT-1.
  function automatic void build_model();
    exp_a.delete(); exp_b.delete(); exp_l.delete();
    foreach (in_q[n])
      for (int k = 0; k < NT; k++) begin
        exp_a.push_back((n - k >= 0) ? in_q[n-k] : '0);
        exp_b.push_back(coef_m[k]);
        exp_l.push_back(k == NT - 1);
      end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    in_q.delete(); got_a.delete(); got_b.delete(); got_l.delete(); got_c.delete();
    stall_viol = 0; rdy_viol = 0;
  endtask

  task automatic apply_reset();
    rst = 1; s_axis_tvalid = 0; coef_wr_en = 0; m_axis_tready = 0;
    repeat (2) tick();
    clear_obs();
    for (int k = 0; k < NT; k++) coef_m[k] = '0;
    rst = 0;
  endtask

  task automatic write_coef(input int addr, input logic signed [BDW-1:0] val);
    coef_wr_en = 1; coef_wr_addr = AW'(addr); coef_wr_data = val;
    tick();
    coef_wr_en = 0;
    coef_m[addr] = val;
  endtask

  task automatic wait_beats(input int n);
    for (int g = 0; g < 400; g++) begin
      if (got_a.size() >= n) break;
      tick();
    end
  endtask

  task automatic stream(input int n, input bit rand_rdy);
    int sent = 0, guard = 0;
    bit hs;
    s_axis_tvalid = 1; s_axis_tdata = ADW'($urandom);
    while (sent < n && guard < 2000) begin
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        if (sent < n) s_axis_tdata = ADW'($urandom); else s_axis_tvalid = 0;
      end
      guard++;
    end
    s_axis_tvalid = 0;
    while (got_a.size() < n * NT && guard < 4000) begin
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end
    m_axis_tready = 0;
  endtask

  task automatic test_reset();
    rst = 1; s_axis_tvalid = 1; m_axis_tready = 1;
    repeat (2) tick();
    vecs++; if (m_axis_tvalid !== 1'b0) begin errs++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
    vecs++; if (m_axis_tlast !== 1'b0) begin errs++; $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
    vecs++; if (m_axis_atdata !== '0) begin errs++; $display("FAIL rst_atdata got=%0d exp=0", m_axis_atdata); end
    vecs++; if (m_axis_btdata !== '0) begin errs++; $display("FAIL rst_btdata got=%0d exp=0", m_axis_btdata); end
    vecs++; if (s_axis_tready !== 1'b0) begin errs++; $display("FAIL rst_tready got=%b exp=0", s_axis_tready); end
    s_axis_tvalid = 0; m_axis_tready = 0;
  endtask

  task automatic test_basic();
    int acc = 0;
    apply_reset();
    for (int k = 0; k < NT; k++) write_coef(k, BDW'(k + 1));
    s_axis_tvalid = 1; s_axis_tdata = 24'sd5;
    @(negedge clk);
    vecs++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin errs++;
      $display("FAIL basic_pre tvalid=%b tready=%b exp tvalid=0 tready=1", m_axis_tvalid, s_axis_tready); end
    @(posedge clk); #1;
    s_axis_tvalid = 0;
    vecs++; if (m_axis_tvalid !== 1'b1 || m_axis_atdata !== 24'sd5 || m_axis_btdata !== 18'sd1) begin errs++;
      $display("FAIL basic_latency tvalid=%b a=%0d b=%0d exp 1,5,1", m_axis_tvalid, m_axis_atdata, m_axis_btdata); end
    m_axis_tready = 1; wait_beats(NT); m_axis_tready = 0;
    s_axis_tvalid = 1; s_axis_tdata = 24'sd7; tick(); s_axis_tvalid = 0;
    m_axis_tready = 1; wait_beats(2 * NT); m_axis_tready = 0;
    build_model();
    vecs++; if (got_a.size() !== exp_a.size()) begin errs++;
      $display("FAIL basic_count got=%0d exp=%0d", got_a.size(), exp_a.size()); end
    else foreach (exp_a[i]) begin
      vecs++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin errs++;
        $display("FAIL basic_beat%0d got=(%0d,%0d,%0b) exp=(%0d,%0d,%0b)", i, got_a[i], got_b[i], got_l[i],
                 exp_a[i], exp_b[i], exp_l[i]); end
    end
    if (got_a.size() >= 2 * NT) for (int i = NT; i < 2 * NT; i++) acc += got_a[i] * got_b[i];
    vecs++; if (acc !== 17) begin errs++; $display("FAIL basic_macc got=%0d exp=17", acc); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < NT; k++) write_coef(k, BDW'($urandom));
    stream(8, 1'b0);
    build_model();
    vecs++; if (got_a.size() !== 8 * NT) begin errs++; $display("FAIL b2b_count got=%0d exp=%0d", got_a.size(), 8 * NT); end
    else begin
      foreach (exp_a[i]) begin
        vecs++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin errs++;
          $display("FAIL b2b_beat%0d got=(%0d,%0d,%0b) exp=(%0d,%0d,%0b)", i, got_a[i], got_b[i], got_l[i],
                   exp_a[i], exp_b[i], exp_l[i]); end
      end
      vecs++; if (got_c[8*NT-1] - got_c[0] !== 8 * NT - 1) begin errs++;
        $display("FAIL b2b_span got=%0d exp=%0d", got_c[8*NT-1] - got_c[0], 8 * NT - 1); end
    end
    vecs++; if (rdy_viol !== 0) begin errs++; $display("FAIL b2b_tready_midframe got=%0d exp=0", rdy_viol); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int k = 0; k < NT; k++) write_coef(k, BDW'($urandom));
    stream(8, 1'b1);
    build_model();
    vecs++; if (got_a.size() !== 8 * NT) begin errs++; $display("FAIL bp_count got=%0d exp=%0d", got_a.size(), 8 * NT); end
    else foreach (exp_a[i]) begin
      vecs++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin errs++;
        $display("FAIL bp_beat%0d got=(%0d,%0d,%0b) exp=(%0d,%0d,%0b)", i, got_a[i], got_b[i], got_l[i],
                 exp_a[i], exp_b[i], exp_l[i]); end
    end
    vecs++; if (stall_viol !== 0) begin errs++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
    vecs++; if (rdy_viol !== 0) begin errs++; $display("FAIL bp_tready_midframe got=%0d exp=0", rdy_viol); end
  endtask

  task automatic test_coef_update();
    apply_reset();
    for (int k = 0; k < NT; k++) write_coef(k, BDW'(k + 1));
    s_axis_tvalid = 1; s_axis_tdata = AMIN; tick(); s_axis_tvalid = 0;
    vecs++; if (m_axis_atdata !== AMIN || m_axis_btdata !== 18'sd1) begin errs++;
      $display("FAIL coef_beat0 got=(%0d,%0d) exp=(%0d,1)", m_axis_atdata, m_axis_btdata, AMIN); end
    m_axis_tready = 1; tick(); m_axis_tready = 0;
    coef_wr_en = 1; coef_wr_addr = 2'd2; coef_wr_data = BMIN; tick(); coef_wr_en = 0;
    vecs++; if (m_axis_btdata !== 18'sd2) begin errs++; $display("FAIL coef_beat1_held got=%0d exp=2", m_axis_btdata); end
    m_axis_tready = 1; tick();
    vecs++; if (m_axis_btdata !== BMIN || m_axis_atdata !== '0 || m_axis_tlast !== 1'b0) begin errs++;
      $display("FAIL coef_beat2 got=(%0d,%0d,%0b) exp=(0,%0d,0)", m_axis_atdata, m_axis_btdata, m_axis_tlast, BMIN); end
    coef_wr_en = 1; coef_wr_addr = 2'd3; coef_wr_data = 18'sd1234; tick(); coef_wr_en = 0; m_axis_tready = 0;
    vecs++; if (m_axis_btdata !== 18'sd4 || m_axis_tlast !== 1'b1) begin errs++;
      $display("FAIL coef_same_edge got=(%0d,%0b) exp=(4,1)", m_axis_btdata, m_axis_tlast); end
    m_axis_tready = 1; tick(); m_axis_tready = 0;
    vecs++; if (m_axis_tvalid !== 1'b0) begin errs++; $display("FAIL coef_frame_end got=%b exp=0", m_axis_tvalid); end
    s_axis_tvalid = 1; s_axis_tdata = 24'sd3; tick(); s_axis_tvalid = 0;
    m_axis_tready = 1; tick();
    vecs++; if (m_axis_atdata !== AMIN || m_axis_btdata !== 18'sd2) begin errs++;
      $display("FAIL coef_f2_beat1 got=(%0d,%0d) exp=(%0d,2)", m_axis_atdata, m_axis_btdata, AMIN); end
    tick(); tick(); m_axis_tready = 0;
    vecs++; if (m_axis_btdata !== 18'sd1234 || m_axis_tlast !== 1'b1) begin errs++;
      $display("FAIL coef_f2_beat3 got=(%0d,%0b) exp=(1234,1)", m_axis_btdata, m_axis_tlast); end
  endtask

  task automatic test_reset_mid();
    int lasts = 0;
    apply_reset();
    for (int k = 0; k < NT; k++) write_coef(k, BDW'(k + 10));
    s_axis_tvalid = 1; s_axis_tdata = ADW'($urandom); tick(); s_axis_tvalid = 0;
    m_axis_tready = 1; tick(); tick(); m_axis_tready = 0;
    vecs++; if (m_axis_tvalid !== 1'b1 || m_axis_btdata !== coef_m[2]) begin errs++;
      $display("FAIL rmid_beat2 got=(%b,%0d) exp=(1,%0d)", m_axis_tvalid, m_axis_btdata, coef_m[2]); end
    rst = 1; coef_wr_en = 1; coef_wr_addr = '0; coef_wr_data = 18'sd77; s_axis_tvalid = 1; tick();
    vecs++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_atdata !== '0 || m_axis_btdata !== '0) begin errs++;
      $display("FAIL rmid_clear got=(%b,%b,%0d,%0d) exp=(0,0,0,0)", m_axis_tvalid, m_axis_tlast, m_axis_atdata, m_axis_btdata); end
    vecs++; if (s_axis_tready !== 1'b0) begin errs++; $display("FAIL rmid_tready got=%b exp=0", s_axis_tready); end
    tick();
    rst = 0; coef_wr_en = 0; s_axis_tvalid = 0;
    foreach (got_l[i]) lasts += got_l[i];
    vecs++; if (got_a.size() !== 2 || lasts !== 0) begin errs++;
      $display("FAIL rmid_aborted beats=%0d lasts=%0d exp beats=2 lasts=0", got_a.size(), lasts); end
    clear_obs();
    for (int k = 0; k < NT; k++) coef_m[k] = '0;
    m_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = 24'sd9; tick(); s_axis_tvalid = 0;
    wait_beats(NT); m_axis_tready = 0;
    build_model();
    vecs++; if (got_a.size() !== NT) begin errs++; $display("FAIL rmid_count got=%0d exp=%0d", got_a.size(), NT); end
    else foreach (exp_a[i]) begin
      vecs++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin errs++;
        $display("FAIL rmid_beat%0d got=(%0d,%0d,%0b) exp=(%0d,%0d,%0b)", i, got_a[i], got_b[i], got_l[i],
                 exp_a[i], exp_b[i], exp_l[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_coef_update();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/macc_frame_gen.md
Name: macc_frame_gen

Overview:
Producer side of the Macc (A, B, tlast) pair-stream interface, the upstream half of a direct-form FIR.
- Accepts one signed sample per input handshake and shifts it into an NTAPS-deep delay line.
- For each accepted sample, emits one frame of NTAPS (sample, coefficient) beats with tlast on the final beat.
- Coefficients come from a local register file written through a simple write port.

Parameters:
ADW, 24, sample width (A data)
BDW, 18, coefficient width (B data)
NTAPS, 16, taps per frame; legal range 2..256
AW, $clog2(NTAPS), coefficient address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_tdata  in  ADW  signed input sample
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  AW  coefficient index, 0..NTAPS-1
coef_wr_data  in  BDW  signed coefficient
m_axis_atdata  out  ADW  delayed sample x[n-k]
m_axis_btdata  out  BDW  coefficient h[k]
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  high on beat k = NTAPS-1

Behaviour:
- Delay line: dly[0..NTAPS-1]. On an input handshake, dly[0] <= sample and dly[i] <= dly[i-1]. The oldest value drops out.
- Coefficient array: coef[0..NTAPS-1].
  - A write with coef_wr_en=1 updates coef[addr] at the clock edge.
  - Writes with addr >= NTAPS are ignored.
- Output registers: m_axis_* are all registered. Internal tap counter tap ranges 0..NTAPS-1.
- Two states:
  - IDLE: m_axis_tvalid=0.
  - EMIT: m_axis_tvalid=1.
- Input ready: s_axis_tready = !m_axis_tvalid || (m_axis_tready && m_axis_tlast). This is combinational from the registered state and does not depend on s_axis_tvalid.
- Frame start, on an input handshake:
  - Next edge loads atdata=new sample, btdata=coef[0], tap=0, tlast=(NTAPS==1 ? 1 : 0), tvalid=1, state=EMIT.
  - Latency is one cycle from the input handshake to the first valid beat.
- Beat advance, on an output handshake with tlast=0:
  - tap <= tap+1.
  - atdata <= dly[tap+1] (the post-shift delay line).
  - btdata <= coef[tap+1].
  - tlast <= (tap+1 == NTAPS-1).
- Frame end, on an output handshake with tlast=1:
  - With no simultaneous input handshake: tvalid <= 0, tlast <= 0, state=IDLE.
  - With a simultaneous input handshake: the frame-start load takes precedence and the next frame follows back-to-back with no bubble. Sustained throughput is one sample per NTAPS cycles.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable and no input is accepted.
- Coefficient read timing: each load samples coef[] before the current edge's write, so a write at edge E affects only beats loaded after E.
  - Writes mid-frame are legal. Beats already loaded keep the old value.
  - Same-edge write and load to the same index delivers the old value.
- Data widths: no arithmetic. Samples and coefficients pass bit-exact, and signedness is preserved.
- Reset (rst=1 at an edge), overriding all else, including a mid-frame reset:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_atdata=0, m_axis_btdata=0.
  - tap=0, state=IDLE, all dly[]=0, all coef[]=0.
  - An in-progress frame is aborted with no tlast beat. The downstream accumulator is expected to be reset in the same cycle.
- Throughout rst: s_axis_tready=0 and coefficient writes are ignored.
- Frame contents: after reset, the first frame's older taps carry zeros from the cleared delay line.

Test Plan:
- Basic frame: NTAPS=4, coef={1,2,3,4}, input 5 -> beats (5,1),(0,2),(0,3),(0,4), tlast only on the 4th; tvalid rises one cycle after the handshake.
- Delay line: inputs 5 then 7 -> second frame (7,1),(5,2),(0,3),(0,4); feeding Macc gives outputs 5 then 17.
- Back-to-back: tvalid held on both sides, m_axis_tready=1, 8 samples -> 32 contiguous beats with no idle cycle and tlast every 4th beat.
- Backpressure: m_axis_tready toggled randomly -> outputs stable while stalled, s_axis_tready=0 mid-frame, beat sequence identical to the no-stall run.
- Coefficient update and extremes: write coef[2]=-131072 while beat 1 is presented; input -8388608 -> beat 2 carries the new coefficient with signs preserved; a same-edge write and read of coef[3] delivers the old value.
- Reset mid-frame: rst asserted during beat 2 -> tvalid=0 next cycle, no tlast emitted, coef and dly read back as zero on the next frame (btdata=0 for all beats).
